// File: rtl/hamming_disp_sched_if.sv
// Decoder handshake and display bus seen by the Hamming check/display sequencer.
// master = sequencer side, slave = decoder/switch/display side.
interface hamming_disp_sched_if;
  logic [3:0] i_data;
  logic [3:0] i_corr;
  logic [2:0] i_synd;
  logic       i_valid;
  logic       o_req;
  logic [3:0] o_nibble;
  logic [3:0] o_an;
  logic       o_err;
  logic       o_timeout;

  modport master (
    input  i_data, i_corr, i_synd, i_valid,
    output o_req, o_nibble, o_an, o_err, o_timeout
  );

  modport slave (
    output i_data, i_corr, i_synd, i_valid,
    input  o_req, o_nibble, o_an, o_err, o_timeout
  );
endinterface

// File: rtl/hamming_disp_sched.sv
// Periodically requests a Hamming(7,4) decode, snapshots raw/corrected/syndrome,
// and time-multiplexes four result digits onto one seven-segment bus with blanking.
module hamming_disp_sched #(
  parameter int CLK_HZ       = 27_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 270,
  parameter int REQ_PERIOD   = 64,
  parameter int TIMEOUT      = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_disp_sched_if.master bus
);

  localparam int SLOT = CLK_HZ / REFRESH_HZ;
  localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int PW   = (REQ_PERIOD > 1) ? $clog2(REQ_PERIOD) : 1;
  localparam int WW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SW-1:0] SLOT_LAST   = SW'(SLOT - 1);
  localparam logic [SW-1:0] BLANK_END   = SW'(BLANK_CYCLES);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(REQ_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    nibble_q, nibble_d;
  logic          slot_wrap;
  logic          slot_active_d;
  logic          period_hit;

  state_e        state_q;
  logic [WW-1:0] wait_cnt_q;
  logic [WW-1:0] wait_inc;
  logic          accept;
  logic [3:0]    snap_data_q;
  logic [3:0]    snap_corr_q;
  logic [2:0]    snap_synd_q;
  logic          req_q;
  logic          err_q;
  logic          timeout_q;

  logic [3:0]    digit_val [4];

  always_comb begin
    digit_val[0] = snap_data_q;
    digit_val[1] = snap_corr_q;
    digit_val[2] = {1'b0, snap_synd_q};
    digit_val[3] = (snap_synd_q != 3'd0) ? 4'hE : 4'h0;
  end

  // Next-state values drive the registered anodes/nibble so they line up with slot_cnt_q.
  always_comb begin
    slot_wrap    = (slot_cnt_q == SLOT_LAST);
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + SW'(1);
    digit_d      = slot_wrap ? digit_q + 2'd1 : digit_q;
    period_cnt_d = period_cnt_q;
    if (slot_wrap) begin
      period_cnt_d = (period_cnt_q == PERIOD_LAST) ? '0 : period_cnt_q + PW'(1);
    end
    period_hit    = slot_wrap && (period_cnt_q == PERIOD_LAST);
    slot_active_d = (slot_cnt_d >= BLANK_END);
    nibble_d      = slot_wrap ? digit_val[digit_d] : nibble_q;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_d[gi] = ~(slot_active_d && (digit_d == 2'(gi)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      digit_q      <= 2'd0;
      period_cnt_q <= '0;
      an_q         <= 4'b1111;
      nibble_q     <= 4'h0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_q      <= digit_d;
      period_cnt_q <= period_cnt_d;
      an_q         <= an_d;
      nibble_q     <= nibble_d;
    end
  end

  assign wait_inc = wait_cnt_q + WW'(1);
  assign accept   = (state_q != ST_IDLE) && bus.i_valid;

  // A decoder answer in REQ or WAIT always wins, including on the timeout cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      snap_data_q <= 4'h0;
      snap_corr_q <= 4'h0;
      snap_synd_q <= 3'd0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (period_hit) begin
            snap_data_q <= bus.i_data;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          wait_cnt_q <= '0;
          if (bus.i_valid) begin
            state_q <= ST_IDLE;
          end else begin
            req_q   <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_inc;
          if (bus.i_valid) begin
            state_q <= ST_IDLE;
          end else if (wait_inc == WAIT_LIMIT) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (accept) begin
        snap_corr_q <= bus.i_corr;
        snap_synd_q <= bus.i_synd;
        err_q       <= (bus.i_synd != 3'd0);
        timeout_q   <= 1'b0;
        req_q       <= 1'b0;
      end
    end
  end

  assign bus.o_req     = req_q;
  assign bus.o_nibble  = nibble_q;
  assign bus.o_an      = an_q;
  assign bus.o_err     = err_q;
  assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_hamming_disp_sched.sv
// Randomized self-checking bench: every cycle the outputs are compared with a
// model driven by absolute cycle count, slot arithmetic and request age.
module tb_hamming_disp_sched;
  localparam int CLK_HZ     = 27000;
  localparam int REFRESH_HZ = 1000;
  localparam int BLANK      = 3;
  localparam int REQ_PERIOD = 4;
  localparam int TIMEOUT    = 20;
  localparam int SLOT       = CLK_HZ / REFRESH_HZ;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hamming_disp_sched_if bus ();

  hamming_disp_sched #(
    .CLK_HZ      (CLK_HZ),
    .REFRESH_HZ  (REFRESH_HZ),
    .BLANK_CYCLES(BLANK),
    .REQ_PERIOD  (REQ_PERIOD),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int req_hi = 0;

  // Reference model state: cycles since reset, snapshots, outstanding request age.
  int         m_t    = 0;
  logic [3:0] m_data = 4'h0;
  logic [3:0] m_corr = 4'h0;
  logic [2:0] m_synd = 3'd0;
  bit         m_err  = 1'b0;
  bit         m_to   = 1'b0;
  bit         m_busy = 1'b0;
  int         m_age  = 0;
  logic [3:0] m_nib  = 4'h0;

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] digit_of(int d);
    case (d)
      0:       return m_data;
      1:       return m_corr;
      2:       return {1'b0, m_synd};
      default: return (m_synd != 3'd0) ? 4'hE : 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] onehot;
    if ((m_t % SLOT) < BLANK) return 4'hF;
    onehot = 4'b0001 << ((m_t / SLOT) % 4);
    return ~onehot;
  endfunction

  task automatic model_edge();
    bit wrap;
    int new_slot;
    if (!rst_n) begin
      m_t = 0; m_data = 4'h0; m_corr = 4'h0; m_synd = 3'd0;
      m_err = 1'b0; m_to = 1'b0; m_busy = 1'b0; m_age = 0; m_nib = 4'h0;
    end else begin
      wrap     = ((m_t % SLOT) == SLOT - 1);
      new_slot = (m_t + 1) / SLOT;
      if (wrap) m_nib = digit_of(new_slot % 4);
      if (m_busy) begin
        if (bus.i_valid) begin
          m_corr = bus.i_corr; m_synd = bus.i_synd;
          m_err = (bus.i_synd != 3'd0); m_to = 1'b0; m_busy = 1'b0;
          $display("[%0t] capture data=%h corr=%h synd=%0d age=%0d", $time, m_data, m_corr, m_synd, m_age);
        end else if (m_age == TIMEOUT) begin
          m_to = 1'b1; m_busy = 1'b0;
          $display("[%0t] request timed out", $time);
        end else begin
          m_age++;
        end
      end else if (wrap && (new_slot % REQ_PERIOD) == 0) begin
        m_busy = 1'b1; m_age = 0; m_data = bus.i_data;
      end
      m_t++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an", bus.o_an, exp_an());
    chk("nibble", bus.o_nibble, m_nib);
    chk("req", bus.o_req, (m_busy && m_age >= 1) ? 1 : 0);
    chk("err", bus.o_err, m_err);
    chk("timeout", bus.o_timeout, m_to);
    if (bus.o_req) req_hi++;
    else req_hi = 0;
  endtask

  // Decoder emulation: answer dly cycles into o_req (pulse or level), -1 = never.
  task automatic cycle(int dly, bit lvl, bit noise);
    bit v;
    v = 1'b0;
    if (bus.o_req && dly >= 0) v = lvl ? (req_hi >= dly + 1) : (req_hi == dly + 1);
    if (noise && !bus.o_req) begin
      if ($urandom_range(15) == 0) begin
        v = 1'b1;
        bus.i_corr = 4'($urandom);
        bus.i_synd = 3'($urandom);
      end
      if ($urandom_range(7) == 0) bus.i_data = 4'($urandom);
    end
    bus.i_valid = v;
    step();
  endtask

  task automatic run(int n, int dly, bit lvl, bit noise);
    for (int i = 0; i < n; i++) cycle(dly, lvl, noise);
  endtask

  int n_cyc;
  int r_dly;
  bit r_lvl;
  bit r_noise;

  initial begin
    bus.i_data = 4'h0; bus.i_corr = 4'h0; bus.i_synd = 3'd0; bus.i_valid = 1'b0;
    rst_n = 1'b0;
    run(5, -1, 1'b0, 1'b0);
    chk("rst_an_c", bus.o_an, 4'hF);
    chk("rst_req_c", bus.o_req, 0);
    chk("rst_nib_c", bus.o_nibble, 0);
    rst_n = 1'b1;

    bus.i_data = 4'h5; bus.i_corr = 4'h5; bus.i_synd = 3'd5;
    run(250, 3, 1'b0, 1'b0);
    chk("err_set", bus.o_err, 1);

    bus.i_data = 4'hA; bus.i_corr = 4'hA; bus.i_synd = 3'd0;
    run(216, 1, 1'b0, 1'b0);
    chk("err_clr", bus.o_err, 0);

    run(216, -1, 1'b0, 1'b0);
    chk("to_set", bus.o_timeout, 1);

    bus.i_data = 4'h3; bus.i_corr = 4'h3; bus.i_synd = 3'd0;
    run(216, 2, 1'b1, 1'b0);
    chk("to_clr", bus.o_timeout, 0);

    bus.i_data = 4'h6; bus.i_corr = 4'h7; bus.i_synd = 3'd1;
    run(216, TIMEOUT - 1, 1'b0, 1'b0);
    chk("last_cycle_to", bus.o_timeout, 0);
    chk("last_cycle_err", bus.o_err, 1);

    run(432, 4, 1'b0, 1'b1);

    for (int i = 0; i < 300 && !bus.o_req; i++) cycle(-1, 1'b0, 1'b0);
    chk("req_seen", bus.o_req, 1);
    run(5, -1, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(-1, 1'b0, 1'b0);
    chk("mid_rst_an", bus.o_an, 4'hF);
    chk("mid_rst_req", bus.o_req, 0);
    chk("mid_rst_err", bus.o_err, 0);
    chk("mid_rst_nib", bus.o_nibble, 0);
    run(4, -1, 1'b0, 1'b0);
    rst_n = 1'b1;
    run(2, -1, 1'b0, 1'b0);
    chk("post_rst_blank", bus.o_an, 4'hF);
    run(1, -1, 1'b0, 1'b0);
    chk("post_rst_an0", bus.o_an, 4'hE);

    for (int k = 0; k < 40; k++) begin
      bus.i_data = 4'($urandom);
      bus.i_corr = 4'($urandom);
      bus.i_synd = 3'($urandom);
      r_dly   = int'($urandom_range(23)) - 1;
      r_lvl   = 1'($urandom);
      r_noise = 1'($urandom);
      n_cyc   = int'($urandom_range(300, 50));
      if ($urandom_range(7) == 0) begin
        run(n_cyc / 2, r_dly, r_lvl, r_noise);
        rst_n = 1'b0;
        run(int'($urandom_range(6, 1)), r_dly, r_lvl, r_noise);
        rst_n = 1'b1;
        run(n_cyc - n_cyc / 2, r_dly, r_lvl, r_noise);
      end else begin
        run(n_cyc, r_dly, r_lvl, r_noise);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
